// File: rtl/button_pulse_gen.sv
// button_pulse_gen: turns a raw, bouncy, active-low push-button into clean
// single-cycle strobes. The input is synchronised with two flops, then
// debounced on both press and release.
// Optional feature macro: BUTTON_AUTOREPEAT_EN
//   defined     -> holding the key past HOLD_CYCLES starts auto-repeat pulses
//                  every REPEAT_CYCLES.
//   not defined -> exactly one pulse per debounced press; St_Repeat (011) is
//                  treated as an illegal code.
module button_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic       C_CLOCK_50,
  input  logic       C_Reset,
  input  logic       C_Button_In,
  output logic       C_Pulse_Out,
  output logic       C_Pressed_Out,
  output logic [2:0] C_State_Out
);

  typedef enum logic [2:0] {
    St_Idle     = 3'b000,
    St_Debounce = 3'b001,
    St_Held     = 3'b010,
    St_Repeat   = 3'b011,
    St_Release  = 3'b100
  } state_t;

  // Pulses must never land on adjacent cycles; every terminal count needs >= 2.
  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("button_pulse_gen: all cycle parameters must be >= 2");
  end

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             btn_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             pressed_q, pressed_d;

  // Two-flop synchroniser; the key is active-low, so invert after sync.
  always_comb begin
    sync1_d = C_Button_In;
    sync2_d = sync1_q;
  end

  assign btn_s = ~sync2_q;

  // Next-state, counter and strobe. A key drop always takes priority over a
  // terminal count on the same edge, so a drop never produces a pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      St_Idle: begin
        cnt_d = '0;
        if (btn_s) state_d = St_Debounce;
      end
      St_Debounce: begin
        if (!btn_s) begin
          state_d = St_Idle;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = St_Held;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      St_Held: begin
        if (!btn_s) begin
          state_d = St_Release;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
`ifdef BUTTON_AUTOREPEAT_EN
          state_d = St_Repeat;
          cnt_d   = '0;
          pulse_d = 1'b1;
`else
          cnt_d   = cnt_q;  // no auto-repeat: sit saturated until release
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef BUTTON_AUTOREPEAT_EN
      St_Repeat: begin
        if (!btn_s) begin
          state_d = St_Release;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      St_Release: begin
        // Key seen down again while releasing is bounce: back to Held silently.
        if (btn_s) begin
          state_d = St_Held;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = St_Idle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = St_Idle;
        cnt_d   = '0;
      end
    endcase
    pressed_d = (state_d == St_Held) || (state_d == St_Repeat) ||
                (state_d == St_Release);
  end

  // State, counter and registered outputs; sync flops reset to released level.
  always_ff @(posedge C_CLOCK_50) begin
    if (C_Reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= St_Idle;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      pressed_q <= pressed_d;
    end
  end

  assign C_Pulse_Out   = pulse_q;
  assign C_Pressed_Out = pressed_q;
  assign C_State_Out   = state_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen with small timing parameters.
// Expected values follow the edge-by-edge timeline of the key input.
module tb_button_pulse_gen;
  localparam int DEB = 4, HOLD = 20, REP = 8, W = 6;

  logic       clk = 1'b0;
  logic       rst, key;
  logic       pulse, pressed;
  logic [2:0] st;
  int         errs = 0, checks = 0;
  int         npulse;
  logic [31:0] exp_st;
  logic        exp_p;

  button_pulse_gen #(
    .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(W)
  ) dut (
    .C_CLOCK_50   (clk),
    .C_Reset      (rst),
    .C_Button_In  (key),
    .C_Pulse_Out  (pulse),
    .C_Pressed_Out(pressed),
    .C_State_Out  (st)
  );

  always #5 clk = ~clk;

  // Drive inputs, take one rising edge, then settle before sampling.
  task automatic cyc(input logic k, input logic r);
    key = k;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int e, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s[%0d]: observed=%0d expected=%0d", tag, e, obs, exp);
    end
  endtask

  function automatic logic rep_edge(input int e);
    int lst[7];
    lst = '{7, 27, 35, 43, 51, 59, 67};
`ifdef BUTTON_AUTOREPEAT_EN
    foreach (lst[i]) if (lst[i] == e) return 1'b1;
    return 1'b0;
`else
    return (e == lst[0]);
`endif
  endfunction

  initial begin
    key = 1'b1;
    rst = 1'b1;

    // Reset held 3 cycles with key released
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 1'b1);
      chk("rst_pulse", i, 32'(pulse), 0);
      chk("rst_pressed", i, 32'(pressed), 0);
      chk("rst_state", i, 32'(st), 0);
    end
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("idle_state", 0, 32'(st), 0);

    // Clean press of 12 cycles, then release
    for (int e = 1; e <= 25; e++) begin
      cyc((e <= 12) ? 1'b0 : 1'b1, 1'b0);
      exp_st = (e < 3) ? 0 : (e < 7) ? 1 : (e < 15) ? 2 : (e < 19) ? 4 : 0;
      chk("t2_pulse", e, 32'(pulse), 32'(e == 7));
      chk("t2_pressed", e, 32'(pressed), 32'(e >= 7 && e < 19));
      chk("t2_state", e, 32'(st), exp_st);
    end

    // Bounce: low 3 / high 1, ten times
    for (int e = 1; e <= 40; e++) begin
      cyc((((e - 1) % 4) < 3) ? 1'b0 : 1'b1, 1'b0);
      chk("t3_pulse", e, 32'(pulse), 0);
      chk("t3_notheld", e, 32'(st == 3'b010), 0);
    end
    for (int e = 41; e <= 46; e++) cyc(1'b1, 1'b0);
    chk("t3_settle", 46, 32'(st), 0);

    // Long hold of 70 cycles
    npulse = 0;
    for (int e = 1; e <= 80; e++) begin
      cyc((e <= 70) ? 1'b0 : 1'b1, 1'b0);
      chk("t4_pulse", e, 32'(pulse), 32'(rep_edge(e)));
      npulse += int'(pulse);
      if (e == 70) begin
`ifdef BUTTON_AUTOREPEAT_EN
        chk("t4_state70", e, 32'(st), 3);
`else
        chk("t4_state70", e, 32'(st), 2);
`endif
      end
    end
    chk("t4_state80", 80, 32'(st), 0);
`ifdef BUTTON_AUTOREPEAT_EN
    chk("t4_npulse", 80, 32'(npulse), 7);
`else
    chk("t4_npulse", 80, 32'(npulse), 1);
`endif

    // Release bounce while held: Held -> Release -> Held, no extra pulse
    for (int e = 1; e <= 34; e++) begin
      cyc((e <= 10 || (e >= 13 && e <= 25)) ? 1'b0 : 1'b1, 1'b0);
      exp_st = (e < 3) ? 0 : (e < 7) ? 1 : (e < 13) ? 2 : (e < 15) ? 4 :
               (e < 28) ? 2 : (e < 32) ? 4 : 0;
      chk("t5_pulse", e, 32'(pulse), 32'(e == 7));
      chk("t5_pressed", e, 32'(pressed), 32'(e >= 7 && e < 32));
      chk("t5_state", e, 32'(st), exp_st);
    end

    // Reset in the middle of a hold, key kept down
    for (int e = 1; e <= 30; e++) begin
      cyc(1'b0, 1'b0);
      exp_p = (e == 7);
`ifdef BUTTON_AUTOREPEAT_EN
      exp_p = exp_p | (e == 27);
`endif
      chk("t6_pulse", e, 32'(pulse), 32'(exp_p));
    end
`ifdef BUTTON_AUTOREPEAT_EN
    chk("t6_state30", 30, 32'(st), 3);
`else
    chk("t6_state30", 30, 32'(st), 2);
`endif
    cyc(1'b0, 1'b1);
    chk("t6_rst_pulse", 0, 32'(pulse), 0);
    chk("t6_rst_pressed", 0, 32'(pressed), 0);
    chk("t6_rst_state", 0, 32'(st), 0);
    for (int r = 1; r <= 10; r++) begin
      cyc(1'b0, 1'b0);
      exp_st = (r < 3) ? 0 : (r < 7) ? 1 : 2;
      chk("t6_pulse_r", r, 32'(pulse), 32'(r == 7));
      chk("t6_pressed_r", r, 32'(pressed), 32'(r >= 7));
      chk("t6_state_r", r, 32'(st), exp_st);
    end
    for (int r = 1; r <= 10; r++) begin
      cyc(1'b1, 1'b0);
      chk("t6_rel_pulse", r, 32'(pulse), 0);
    end
    chk("t6_final", 0, 32'(st), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
